hsmc_tx_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer that shares the 17-lane HSMC TX output bus among N_REQ FPGA-fabric requesters. It grants one requester at a time and streams that requester's burst of 16-bit words onto the bus with a frame strobe. It inserts a programmable turnaround gap between bursts and aborts bursts that stall. The top level maps TX_DATA to HSMC_TX_p[15:0] and TX_FRAME to HSMC_TX_p[16].

---
 rtl/hsmc_tx_arbiter.sv | 115 +++++++++++
 tb/tb_hsmc_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsmc_tx_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared HSMC TX bus.
// One requester at a time streams its burst with a frame strobe; stalled bursts are aborted.
module hsmc_tx_arbiter #(
  parameter int          N_REQ      = 4,
  parameter int          LEN_W      = 8,
  parameter int          GAP_CYCLES = 2,
  parameter int          TIMEOUT    = 64,
  parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
  input  logic                   OSC_50_B8A,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*LEN_W-1:0] REQ_LEN,
  input  logic [N_REQ*16-1:0]    IN_DATA,
  input  logic [N_REQ-1:0]       IN_VALID,
  output logic [N_REQ-1:0]       IN_READY,
  output logic [N_REQ-1:0]       GNT,
  output logic [15:0]            TX_DATA,
  output logic                   TX_FRAME,
  output logic                   BUSY,
  output logic                   ABORT
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  // With no gap configured a finished burst returns straight to arbitration.
  localparam state_t POST_BURST = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    winner;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [SW-1:0]    stall_cnt;
  logic [3:0]       gap_cnt;

  // Scan offsets from the top down so the set bit closest to ptr is written last.
  always_comb begin
    winner = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (REQ[(int'(ptr) + i) % N_REQ]) winner = IW'((int'(ptr) + i) % N_REQ);
    end
  end

  always_ff @(posedge OSC_50_B8A or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      GNT       <= '0;
      TX_DATA   <= IDLE_WORD;
      TX_FRAME  <= 1'b0;
      ABORT     <= 1'b0;
      ptr       <= '0;
      gidx      <= '0;
      len       <= '0;
      cnt       <= '0;
      stall_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      TX_DATA  <= IDLE_WORD;
      TX_FRAME <= 1'b0;
      ABORT    <= 1'b0;
      case (state)
        IDLE: begin
          if (|REQ) begin
            GNT       <= N_REQ'(1) << winner;
            gidx      <= winner;
            len       <= REQ_LEN[int'(winner)*LEN_W +: LEN_W];
            cnt       <= '0;
            stall_cnt <= '0;
            ptr       <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
            state     <= XFER;
          end
        end
        XFER: begin
          if (IN_VALID[gidx]) begin
            TX_DATA   <= IN_DATA[int'(gidx)*16 +: 16];
            TX_FRAME  <= 1'b1;
            cnt       <= cnt + 1'b1;
            stall_cnt <= '0;
            if (cnt == len) begin
              GNT     <= '0;
              gap_cnt <= '0;
              state   <= POST_BURST;
            end
          end else if (TIMEOUT != 0 && stall_cnt == SW'(TIMEOUT)) begin
            ABORT     <= 1'b1;
            GNT       <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            state     <= POST_BURST;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY     = (state != IDLE);
  assign IN_READY = GNT & {N_REQ{state == XFER}};

endmodule

// File: tb/tb_hsmc_tx_arbiter.sv
// Bench for hsmc_tx_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hsmc_tx_arbiter;

  localparam int N = 4;
  localparam int G = 2;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_len;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  gnt;
  logic [15:0] tx_data;
  logic        tx_frame;
  logic        busy;
  logic        abort;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  hsmc_tx_arbiter #(
    .N_REQ(N), .LEN_W(8), .GAP_CYCLES(G), .TIMEOUT(T), .IDLE_WORD(16'h0000)
  ) dut (
    .OSC_50_B8A(clk), .RESET(rst), .REQ(req), .REQ_LEN(req_len), .IN_DATA(in_data),
    .IN_VALID(in_valid), .IN_READY(in_ready), .GNT(gnt), .TX_DATA(tx_data),
    .TX_FRAME(tx_frame), .BUSY(busy), .ABORT(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 bursting, 2 gap; counts words and stalls as plain integers.
  int          m_phase, m_g, m_ptr, m_words, m_sent, m_stall, m_gap;
  logic [3:0]  e_gnt;
  logic [15:0] e_data;
  logic        e_frame, e_abort;

  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; m_g = 0; m_ptr = 0; m_words = 0; m_sent = 0; m_stall = 0; m_gap = 0;
      e_gnt = 0; e_data = 0; e_frame = 0; e_abort = 0;
    end else begin
      e_data = 0; e_frame = 0; e_abort = 0;
      if (m_phase == 0) begin
        if (req != 0) begin
          for (int i = 0; i < N; i++) begin
            if (req[(m_ptr + i) % N]) begin m_g = (m_ptr + i) % N; break; end
          end
          m_words = int'(req_len[m_g*8 +: 8]) + 1;
          m_sent  = 0;
          m_stall = 0;
          m_ptr   = (m_g + 1) % N;
          e_gnt   = 4'(1 << m_g);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (in_valid[m_g]) begin
          e_data  = in_data[m_g*16 +: 16];
          e_frame = 1;
          m_sent++;
          m_stall = 0;
          if (m_sent == m_words) begin
            e_gnt = 0;
            if (G == 0) m_phase = 0; else begin m_phase = 2; m_gap = G; end
          end
        end else if (T != 0 && m_stall == T) begin
          e_abort = 1;
          e_gnt   = 0;
          if (G == 0) m_phase = 0; else begin m_phase = 2; m_gap = G; end
        end else begin
          m_stall++;
        end
      end else begin
        m_gap--;
        if (m_gap == 0) m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("tx_data", 32'(tx_data), 32'(e_data));
      chk("tx_frame", 32'(tx_frame), 32'(e_frame));
      chk("abort", 32'(abort), 32'(e_abort));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("in_ready", 32'(in_ready), 32'(e_gnt & {4{m_phase == 1}}));
    end
  end

  // Activity log used by the directed scenarios.
  int          cyc = 0;
  logic [15:0] frames[$];
  int          fcyc[$], grants[$], gstart[$], gend[$];
  int          abort_cnt, abort_cyc, busy_fall, gnt_hi_cnt;
  logic [3:0]  prev_gnt = 0;
  logic        prev_busy = 0;

  always begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (tx_frame) begin frames.push_back(tx_data); fcyc.push_back(cyc); end
      if (abort) begin abort_cnt++; abort_cyc = cyc; end
      if (gnt != 0) gnt_hi_cnt++;
      if (gnt != 0 && prev_gnt == 0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) grants.push_back(i);
        gstart.push_back(cyc);
      end
      if (gnt == 0 && prev_gnt != 0) gend.push_back(cyc);
      if (!busy && prev_busy) busy_fall = cyc;
    end
    prev_gnt  = gnt;
    prev_busy = busy;
  end

  task automatic clear_stats();
    frames.delete(); fcyc.delete(); grants.delete(); gstart.delete(); gend.delete();
    abort_cnt = 0; abort_cyc = -1; busy_fall = -1; gnt_hi_cnt = 0;
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int qf(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? int'(q[i]) : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int idx, stall_n;

  initial begin
    rst = 1; req = 0; req_len = 0; in_data = 0; in_valid = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_tx_data", 32'(tx_data), 0);
    chk("reset_tx_frame", 32'(tx_frame), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_abort", 32'(abort), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    step();
    rst = 0;
    cmp_en = 1;
    step();

    // Single 4-word burst from requester 1.
    clear_stats();
    req = 4'b0010; req_len = 0; req_len[8 +: 8] = 8'd3; in_valid = 4'b0010; idx = 0;
    for (int c = 0; c < 20; c++) begin
      in_data[16 +: 16] = 16'(16'h00A0 + idx);
      step();
      if (gnt != 0) req = 0;
      if (tx_frame) idx++;
    end
    chk("single_words", 32'(frames.size()), 4);
    for (int i = 0; i < 4; i++) chk("single_data", 32'(qf(frames, i)), 32'(16'h00A0 + i));
    chk("single_grant_idx", 32'(qi(grants, 0)), 1);
    chk("single_gnt_cycles", 32'(gnt_hi_cnt), 4);
    chk("single_first_frame_lat", 32'(qi(fcyc, 0) - qi(gstart, 0)), 1);
    chk("single_contiguous", 32'(qi(fcyc, 3) - qi(fcyc, 0)), 3);
    chk("single_busy_fall", 32'(busy_fall - qi(fcyc, 3)), 32'(G));

    // 8-word burst with a 5-cycle stall after word 3.
    clear_stats();
    req = 4'b0100; req_len = 0; req_len[16 +: 8] = 8'd7; in_valid = 4'b0100; idx = 0; stall_n = 0;
    for (int c = 0; c < 40; c++) begin
      in_data[32 +: 16] = 16'(16'h0200 + idx);
      if (idx == 3 && stall_n < 5 && in_ready[2]) begin in_valid[2] = 0; stall_n++; end
      else in_valid[2] = 1;
      step();
      if (gnt != 0) req = 0;
      if (tx_frame) idx++;
    end
    chk("stall_words", 32'(frames.size()), 8);
    chk("stall_span", 32'(qi(fcyc, 7) - qi(fcyc, 0)), 12);
    chk("stall_no_abort", 32'(abort_cnt), 0);
    for (int i = 0; i < 8; i++) chk("stall_data", 32'(qf(frames, i)), 32'(16'h0200 + i));

    // Requester 0 stalls forever after 2 of 8 words; requester 2 waits behind it.
    clear_stats();
    req = 4'b0101; req_len = 0; req_len[0 +: 8] = 8'd7; in_valid = 4'b0100; idx = 0;
    in_data[32 +: 16] = 16'h0BEE;
    for (int c = 0; c < 150; c++) begin
      in_data[0 +: 16] = 16'(16'h0300 + idx);
      in_valid[0] = (idx < 2);
      step();
      if (gnt[0]) req = 4'b0100;
      if (gnt[2]) req = 0;
      if (tx_frame) idx++;
    end
    chk("timeout_abort_count", 32'(abort_cnt), 1);
    chk("timeout_words", 32'(frames.size()), 3);
    chk("timeout_data0", 32'(qf(frames, 0)), 32'h0300);
    chk("timeout_data1", 32'(qf(frames, 1)), 32'h0301);
    chk("timeout_next_data", 32'(qf(frames, 2)), 32'h0BEE);
    chk("timeout_latency", 32'(abort_cyc - qi(fcyc, 1)), 32'(T + 1));
    chk("timeout_gnt_clear", 32'(qi(gend, 0)), 32'(abort_cyc));
    chk("timeout_grant_order", 32'(qi(grants, 0) * 10 + qi(grants, 1)), 2);
    chk("timeout_next_grant", 32'(qi(gstart, 1) - abort_cyc), 32'(G + 1));

    // Reset asserted while word 3 of a burst is on the bus.
    clear_stats();
    req = 4'b0010; req_len = 0; req_len[8 +: 8] = 8'd7; in_valid = 4'b0010; idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      in_data[16 +: 16] = 16'(16'h0100 + idx);
      step();
      if (gnt != 0) req = 0;
      if (tx_frame) idx++;
    end
    chk("rst_reached_word3", 32'(idx), 3);
    rst = 1;
    #1;
    chk("rst_async_frame", 32'(tx_frame), 0);
    chk("rst_async_gnt", 32'(gnt), 0);
    chk("rst_async_data", 32'(tx_data), 0);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_ready", 32'(in_ready), 0);
    req = 4'b1000; req_len = 0; in_valid = 4'b1000;
    step();
    rst = 0;
    clear_stats();

    // Requester 3 first, then all lines held: pointer wraps and round-robin order holds.
    for (int c = 0; c < 40; c++) begin
      in_data = {$urandom, $urandom};
      step();
      if (gnt[3] && req == 4'b1000) begin req = 4'b1111; in_valid = 4'b1111; end
    end
    req = 0;
    repeat (10) step();
    chk("rr_grant0", 32'(qi(grants, 0)), 3);
    chk("rr_grant1", 32'(qi(grants, 1)), 0);
    chk("rr_grant2", 32'(qi(grants, 2)), 1);
    chk("rr_grant3", 32'(qi(grants, 3)), 2);
    chk("rr_grant4", 32'(qi(grants, 4)), 3);
    chk("rr_grant5", 32'(qi(grants, 5)), 0);
    for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(qi(gstart, i) - qi(gend, i - 1)), 32'(G + 1));

    // Maximum-length burst.
    clear_stats();
    req = 4'b0010; req_len = 0; req_len[8 +: 8] = 8'hFF; in_valid = 4'b0010;
    for (int c = 0; c < 290; c++) begin
      in_data = {$urandom, $urandom};
      step();
      if (gnt != 0) req = 0;
    end
    chk("maxlen_words", 32'(frames.size()), 256);
    chk("maxlen_span", 32'(qi(fcyc, 255) - qi(fcyc, 0)), 255);

    // Randomized traffic checked by the model only.
    for (int c = 0; c < 4000; c++) begin
      req = ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        req_len[i*8 +: 8] = 8'($urandom_range(0, 5));
        in_valid[i]       = ($urandom_range(0, 3) != 0);
      end
      in_data = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
